mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
Two-requester read-address/read-data arbiter that shares one memory read port between instruction fetch (IM) and data load (DM). It sits between the fetch PC logic / load unit and the unified memory read bus. Requests are granted round-robin and registered onto the shared AR channel. Responses return in order and are routed to their originator through an ID-tracking FIFO.

Parameters:
XLEN, 32, address/data width
MAX_OUTSTANDING, 4, max accepted-but-unanswered reads (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
i_im_arvalid  in  1  IM read request valid
o_im_arready  out  1  IM request accepted
i_im_araddr  in  XLEN  IM read address
i_im_arprot  in  3  IM protection bits
o_im_rvalid  out  1  IM read data valid
i_im_rready  in  1  IM ready for data
o_im_rdata  out  XLEN  IM read data
o_im_rresp  out  2  IM response code
i_dm_arvalid / o_dm_arready / i_dm_araddr / i_dm_arprot  same as IM, DM requester
o_dm_rvalid / i_dm_rready / o_dm_rdata / o_dm_rresp  same as IM, DM requester
o_m_arvalid  out  1  shared bus request valid
i_m_arready  in  1  memory accepts request
o_m_araddr  out  XLEN  registered address
o_m_arprot  out  3  registered protection
i_m_rvalid  in  1  memory data valid
o_m_rready  out  1  arbiter ready for data
i_m_rdata  in  XLEN  memory read data
i_m_rresp  in  2  memory response code

Behaviour:
- Reset (async, rst=1): state=ArbIdle, o_m_arvalid=0, o_m_araddr=0, o_m_arprot=0, count=0, FIFO empty, last_grant=ReqDm (IM wins first tie). All arready/rvalid outputs 0 during reset.
- States: ArbIdle, ArbIssue.
- ArbIdle: accept iff count < MAX_OUTSTANDING. Winner: only one valid -> that one; both valid -> the one != last_grant. Winner's arready=1 combinationally in this cycle (other's=0). On accept: register addr/prot into o_m_araddr/o_m_arprot, push winner ID into FIFO, count+1, last_grant<=winner, -> ArbIssue.
- count==MAX_OUTSTANDING: both arready=0, stay ArbIdle. A response pop in the same cycle does not unblock acceptance (full check uses registered count).
- ArbIssue: o_m_arvalid=1; address/prot stable. On i_m_arready=1 -> ArbIdle (o_m_arvalid=0 next cycle). No upstream accept in ArbIssue; peak rate one request per 2 cycles.
- Latency: upstream accept cycle N -> o_m_arvalid=1 at N+1.
- R routing (combinational): head = FIFO head ID. If FIFO non-empty: o_<head>_rvalid=i_m_rvalid, o_m_rready=i_<head>_rready, rdata/rresp broadcast to both; non-head rvalid=0. FIFO empty: o_m_rready=0, both rvalid=0 (unsolicited data stalled).
- Pop FIFO and count-1 on i_m_rvalid && o_m_rready. Accept and pop in the same cycle -> count unchanged, FIFO push+pop both performed.
- count width $clog2(MAX_OUTSTANDING+1); FIFO pointers wrap modulo MAX_OUTSTANDING; no overflow/underflow possible by construction; assertions required for both.
- Requesters follow AXI rules (valid held until arready); the arbiter never drops a granted request.

Decomposition:
- riscv_pkg: typedef enum logic {ArbIdle, ArbIssue} arb_state_e; typedef enum logic {ReqIm=1'b0, ReqDm=1'b1} req_id_e.
- Sub-module resp_order_fifo: 1-bit-wide (req_id_e), depth MAX_OUTSTANDING, push/pop/full/empty/head, async active-high reset.

Test Plan:
- IM only, addr 0x100, i_m_arready=1 -> o_im_arready at cycle N, o_m_araddr=0x100 valid N+1; rdata 0xDEADBEEF returned -> o_im_rvalid=1, o_dm_rvalid=0.
- IM 0x200 and DM 0x3000 both valid after reset -> IM granted first, DM next ArbIdle; responses 0x11, 0x22 routed IM then DM.
- Hold i_m_rvalid=0 and issue 4 reads -> 5th request sees arready=0 until first R handshake, then accepted on following ArbIdle cycle.
- i_m_arready=0 for 5 cycles in ArbIssue -> o_m_arvalid and o_m_araddr stable; single FIFO entry.
- Head=DM, i_dm_rready=0, i_m_rvalid=1 -> o_m_rready=0, no pop; o_im_rvalid stays 0.
- Assert rst during ArbIssue with 2 outstanding -> o_m_arvalid=0 immediately, count=0, next IM request granted first.

Source files
------------

// File: rtl/mem_read_arbiter_pkg.sv
// Shared types for the two-requester memory read arbiter.
package mem_read_arbiter_pkg;

  typedef enum logic {
    ArbIdle  = 1'b0,
    ArbIssue = 1'b1
  } arb_state_e;

  typedef enum logic {
    ReqIm = 1'b0,
    ReqDm = 1'b1
  } req_id_e;

  function automatic req_id_e other_req(input req_id_e r);
    return (r == ReqIm) ? ReqDm : ReqIm;
  endfunction

endpackage

// File: rtl/mem_read_arbiter_resp_order_fifo.sv
// In-order response ID FIFO: remembers which requester owns each outstanding read.
module mem_read_arbiter_resp_order_fifo
  import mem_read_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_e din,
  output req_id_e head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  req_id_e         mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin IM/DM read arbiter onto one shared AR/R memory port with in-order R routing.
module mem_read_arbiter
  import mem_read_arbiter_pkg::*;
#(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_im_arvalid,
  output logic            o_im_arready,
  input  logic [XLEN-1:0] i_im_araddr,
  input  logic [2:0]      i_im_arprot,
  output logic            o_im_rvalid,
  input  logic            i_im_rready,
  output logic [XLEN-1:0] o_im_rdata,
  output logic [1:0]      o_im_rresp,
  input  logic            i_dm_arvalid,
  output logic            o_dm_arready,
  input  logic [XLEN-1:0] i_dm_araddr,
  input  logic [2:0]      i_dm_arprot,
  output logic            o_dm_rvalid,
  input  logic            i_dm_rready,
  output logic [XLEN-1:0] o_dm_rdata,
  output logic [1:0]      o_dm_rresp,
  output logic            o_m_arvalid,
  input  logic            i_m_arready,
  output logic [XLEN-1:0] o_m_araddr,
  output logic [2:0]      o_m_arprot,
  input  logic            i_m_rvalid,
  output logic            o_m_rready,
  input  logic [XLEN-1:0] i_m_rdata,
  input  logic [1:0]      i_m_rresp
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e      state_q, next_state;
  req_id_e         last_grant_q;
  req_id_e         winner;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] araddr_q;
  logic [2:0]      arprot_q;
  logic            accept;
  logic            pop;
  req_id_e         head;
  logic            fifo_full;
  logic            fifo_empty;

  // Next-state and grant selection; acceptance uses the registered count only.
  always_comb begin
    next_state = state_q;
    accept     = 1'b0;
    winner     = ReqIm;
    case (state_q)
      ArbIdle: begin
        if (!rst && (count_q < CW'(MAX_OUTSTANDING)) && (i_im_arvalid || i_dm_arvalid)) begin
          accept     = 1'b1;
          next_state = ArbIssue;
          if (i_im_arvalid && i_dm_arvalid) winner = other_req(last_grant_q);
          else if (i_dm_arvalid)            winner = ReqDm;
          else                              winner = ReqIm;
        end
      end
      ArbIssue: begin
        if (i_m_arready) next_state = ArbIdle;
      end
    endcase
  end

  assign o_im_arready = accept && (winner == ReqIm);
  assign o_dm_arready = accept && (winner == ReqDm);
  assign o_m_arvalid  = (state_q == ArbIssue);
  assign o_m_araddr   = araddr_q;
  assign o_m_arprot   = arprot_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ArbIdle;
      last_grant_q <= ReqDm;
      araddr_q     <= '0;
      arprot_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q <= next_state;
      if (accept) begin
        last_grant_q <= winner;
        araddr_q     <= (winner == ReqIm) ? i_im_araddr : i_dm_araddr;
        arprot_q     <= (winner == ReqIm) ? i_im_arprot : i_dm_arprot;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Response routing follows the oldest outstanding ID; unsolicited data is stalled.
  assign o_m_rready  = !fifo_empty && ((head == ReqIm) ? i_im_rready : i_dm_rready);
  assign o_im_rvalid = !fifo_empty && (head == ReqIm) && i_m_rvalid;
  assign o_dm_rvalid = !fifo_empty && (head == ReqDm) && i_m_rvalid;
  assign o_im_rdata  = i_m_rdata;
  assign o_dm_rdata  = i_m_rdata;
  assign o_im_rresp  = i_m_rresp;
  assign o_dm_rresp  = i_m_rresp;
  assign pop         = i_m_rvalid && o_m_rready;

  mem_read_arbiter_resp_order_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (winner),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_count_tracks_fifo: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (count_q == CW'(MAX_OUTSTANDING)));

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed and randomized checks of mem_read_arbiter against a queue-based reference model.
module tb_mem_read_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned MAX  = 4;

  logic            clk, rst;
  logic            i_im_arvalid, o_im_arready, o_im_rvalid, i_im_rready;
  logic [XLEN-1:0] i_im_araddr, o_im_rdata;
  logic [2:0]      i_im_arprot;
  logic [1:0]      o_im_rresp;
  logic            i_dm_arvalid, o_dm_arready, o_dm_rvalid, i_dm_rready;
  logic [XLEN-1:0] i_dm_araddr, o_dm_rdata;
  logic [2:0]      i_dm_arprot;
  logic [1:0]      o_dm_rresp;
  logic            o_m_arvalid, i_m_arready, i_m_rvalid, o_m_rready;
  logic [XLEN-1:0] o_m_araddr, i_m_rdata;
  logic [2:0]      o_m_arprot;
  logic [1:0]      i_m_rresp;

  int n_checks = 0;
  int n_fail   = 0;

  mem_read_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .i_im_arvalid(i_im_arvalid), .o_im_arready(o_im_arready), .i_im_araddr(i_im_araddr),
    .i_im_arprot(i_im_arprot), .o_im_rvalid(o_im_rvalid), .i_im_rready(i_im_rready),
    .o_im_rdata(o_im_rdata), .o_im_rresp(o_im_rresp),
    .i_dm_arvalid(i_dm_arvalid), .o_dm_arready(o_dm_arready), .i_dm_araddr(i_dm_araddr),
    .i_dm_arprot(i_dm_arprot), .o_dm_rvalid(o_dm_rvalid), .i_dm_rready(i_dm_rready),
    .o_dm_rdata(o_dm_rdata), .o_dm_rresp(o_dm_rresp),
    .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready), .o_m_araddr(o_m_araddr),
    .o_m_arprot(o_m_arprot), .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
    .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_im_arvalid = 0; i_im_araddr = '0; i_im_arprot = '0; i_im_rready = 0;
    i_dm_arvalid = 0; i_dm_araddr = '0; i_dm_arprot = '0; i_dm_rready = 0;
    i_m_arready = 0; i_m_rvalid = 0; i_m_rdata = '0; i_m_rresp = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One IM read through AR with the memory accepting immediately.
  task automatic im_read(input logic [31:0] addr);
    i_im_arvalid = 1; i_im_araddr = addr; i_m_arready = 1;
    @(negedge clk);
    chk("im_read_arready", 32'(o_im_arready), 1);
    tick();
    i_im_arvalid = 0;
    @(negedge clk);
    chk("im_read_araddr", o_m_araddr, addr);
    tick();
  endtask

  // Reference model state for the random phase.
  bit        q_ids[$];
  bit        ar_busy, last_dm, im_pend, dm_pend, can_acc, win, has, hd, e_rready;
  logic [31:0] ar_addr_m;
  logic [2:0]  ar_prot_m;

  initial begin
    rst = 1'b1;
    clear_inputs();
    i_im_arvalid = 1;
    #2;
    chk("rst_arvalid", 32'(o_m_arvalid), 0);
    chk("rst_araddr", o_m_araddr, 0);
    chk("rst_im_arready", 32'(o_im_arready), 0);
    chk("rst_rvalid", 32'({o_im_rvalid, o_dm_rvalid}), 0);
    do_reset();

    // IM only: grant in cycle N, AR valid at N+1, data routed to IM.
    i_im_arvalid = 1; i_im_araddr = 32'h100; i_im_arprot = 3'b101; i_m_arready = 1;
    @(negedge clk);
    chk("t1_im_arready", 32'(o_im_arready), 1);
    chk("t1_dm_arready", 32'(o_dm_arready), 0);
    chk("t1_arvalid_n", 32'(o_m_arvalid), 0);
    tick();
    i_im_arvalid = 0;
    @(negedge clk);
    chk("t1_arvalid_n1", 32'(o_m_arvalid), 1);
    chk("t1_araddr", o_m_araddr, 32'h100);
    chk("t1_arprot", 32'(o_m_arprot), 32'h5);
    tick();
    i_m_rvalid = 1; i_m_rdata = 32'hDEADBEEF; i_im_rready = 1;
    @(negedge clk);
    chk("t1_arvalid_idle", 32'(o_m_arvalid), 0);
    chk("t1_im_rvalid", 32'(o_im_rvalid), 1);
    chk("t1_dm_rvalid", 32'(o_dm_rvalid), 0);
    chk("t1_rdata", o_im_rdata, 32'hDEADBEEF);
    chk("t1_rready", 32'(o_m_rready), 1);
    tick();
    clear_inputs();

    // Simultaneous requests after reset: IM first, DM on the next idle cycle.
    do_reset();
    i_im_arvalid = 1; i_im_araddr = 32'h200; i_dm_arvalid = 1; i_dm_araddr = 32'h3000; i_m_arready = 1;
    @(negedge clk);
    chk("t2_im_first", 32'(o_im_arready), 1);
    chk("t2_dm_wait", 32'(o_dm_arready), 0);
    tick();
    i_im_arvalid = 0;
    @(negedge clk);
    chk("t2_issue_no_accept", 32'(o_dm_arready), 0);
    chk("t2_araddr_im", o_m_araddr, 32'h200);
    tick();
    @(negedge clk);
    chk("t2_dm_second", 32'(o_dm_arready), 1);
    tick();
    i_dm_arvalid = 0;
    @(negedge clk);
    chk("t2_araddr_dm", o_m_araddr, 32'h3000);
    tick();
    i_m_rvalid = 1; i_m_rdata = 32'h11; i_im_rready = 1; i_dm_rready = 1;
    @(negedge clk);
    chk("t2_r1_im", 32'({o_im_rvalid, o_dm_rvalid}), 32'b10);
    tick();
    i_m_rdata = 32'h22;
    @(negedge clk);
    chk("t2_r2_dm", 32'({o_im_rvalid, o_dm_rvalid}), 32'b01);
    chk("t2_r2_data", o_dm_rdata, 32'h22);
    tick();
    clear_inputs();

    // Four outstanding reads block a fifth until a response pops (not in the pop cycle).
    do_reset();
    for (int i = 0; i < 4; i++) im_read(32'h400 + 32'(i * 4));
    i_im_arvalid = 1; i_im_araddr = 32'h500;
    @(negedge clk);
    chk("t3_full_block", 32'(o_im_arready), 0);
    tick();
    i_m_rvalid = 1; i_im_rready = 1;
    @(negedge clk);
    chk("t3_pop_no_unblock", 32'(o_im_arready), 0);
    chk("t3_pop_rvalid", 32'(o_im_rvalid), 1);
    tick();
    i_m_rvalid = 0;
    @(negedge clk);
    chk("t3_unblocked", 32'(o_im_arready), 1);
    tick();
    i_im_arvalid = 0;
    @(negedge clk);
    chk("t3_araddr5", o_m_araddr, 32'h500);
    tick();
    i_m_rvalid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_drain", 32'(o_im_rvalid), 1);
      tick();
    end
    @(negedge clk);
    chk("t3_empty_rready", 32'(o_m_rready), 0);
    chk("t3_empty_rvalid", 32'(o_im_rvalid), 0);
    clear_inputs();

    // Memory stalls AR for 5 cycles: request held stable, one FIFO entry.
    do_reset();
    i_im_arvalid = 1; i_im_araddr = 32'h440; i_m_arready = 0;
    tick();
    i_im_arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_arvalid_hold", 32'(o_m_arvalid), 1);
      chk("t4_araddr_hold", o_m_araddr, 32'h440);
      tick();
    end
    i_m_arready = 1;
    tick();
    i_m_arready = 0; i_m_rvalid = 1; i_im_rready = 1;
    @(negedge clk);
    chk("t4_single_resp", 32'(o_im_rvalid), 1);
    tick();
    @(negedge clk);
    chk("t4_fifo_empty", 32'(o_m_rready), 0);
    clear_inputs();

    // Head is DM and DM not ready: no pop, IM sees nothing.
    do_reset();
    i_dm_arvalid = 1; i_dm_araddr = 32'h880; i_m_arready = 1;
    tick();
    i_dm_arvalid = 0;
    tick();
    i_m_rvalid = 1; i_dm_rready = 0; i_im_rready = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t5_rready_low", 32'(o_m_rready), 0);
      chk("t5_im_rvalid", 32'(o_im_rvalid), 0);
      chk("t5_dm_rvalid", 32'(o_dm_rvalid), 1);
      tick();
    end
    i_dm_rready = 1;
    @(negedge clk);
    chk("t5_rready_high", 32'(o_m_rready), 1);
    tick();
    @(negedge clk);
    chk("t5_popped", 32'(o_m_rready), 0);
    clear_inputs();

    // Async reset during ArbIssue with outstanding reads.
    do_reset();
    im_read(32'h10);
    im_read(32'h14);
    i_im_arvalid = 1; i_im_araddr = 32'h600; i_m_arready = 0;
    tick();
    i_im_arvalid = 0;
    @(negedge clk);
    chk("t6_in_issue", 32'(o_m_arvalid), 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_arvalid", 32'(o_m_arvalid), 0);
    chk("t6_rst_araddr", o_m_araddr, 0);
    tick();
    rst = 1'b0;
    i_im_arvalid = 1; i_im_araddr = 32'h700; i_dm_arvalid = 1; i_dm_araddr = 32'h704;
    i_m_rvalid = 1; i_im_rready = 1;
    @(negedge clk);
    chk("t6_im_wins", 32'({o_im_arready, o_dm_arready}), 32'b10);
    chk("t6_count_zero", 32'(o_m_rready), 0);
    tick();
    clear_inputs();

    // Randomized traffic against the reference model.
    do_reset();
    q_ids.delete();
    ar_busy = 0; last_dm = 1; im_pend = 0; dm_pend = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      if (!im_pend && $urandom_range(0, 1) == 1) begin
        im_pend = 1; i_im_araddr = $urandom; i_im_arprot = 3'($urandom);
      end
      if (!dm_pend && $urandom_range(0, 1) == 1) begin
        dm_pend = 1; i_dm_araddr = $urandom; i_dm_arprot = 3'($urandom);
      end
      i_im_arvalid = im_pend;
      i_dm_arvalid = dm_pend;
      i_m_arready  = ($urandom_range(0, 2) != 0);
      i_m_rvalid   = ($urandom_range(0, 3) == 0);
      i_m_rdata    = $urandom;
      i_m_rresp    = 2'($urandom);
      i_im_rready  = ($urandom_range(0, 2) != 0);
      i_dm_rready  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      can_acc  = !ar_busy && (q_ids.size() < MAX) && (im_pend || dm_pend);
      win      = (im_pend && dm_pend) ? !last_dm : dm_pend;
      has      = q_ids.size() > 0;
      hd       = has ? q_ids[0] : 1'b0;
      e_rready = has && (hd ? i_dm_rready : i_im_rready);
      chk("rnd_im_arready", 32'(o_im_arready), 32'(can_acc && !win));
      chk("rnd_dm_arready", 32'(o_dm_arready), 32'(can_acc && win));
      chk("rnd_arvalid", 32'(o_m_arvalid), 32'(ar_busy));
      if (ar_busy) begin
        chk("rnd_araddr", o_m_araddr, ar_addr_m);
        chk("rnd_arprot", 32'(o_m_arprot), 32'(ar_prot_m));
      end
      chk("rnd_rready", 32'(o_m_rready), 32'(e_rready));
      chk("rnd_im_rvalid", 32'(o_im_rvalid), 32'(has && !hd && i_m_rvalid));
      chk("rnd_dm_rvalid", 32'(o_dm_rvalid), 32'(has && hd && i_m_rvalid));
      if (has && i_m_rvalid) chk("rnd_rresp", 32'(hd ? o_dm_rresp : o_im_rresp), 32'(i_m_rresp));
      if (i_m_rvalid && e_rready) void'(q_ids.pop_front());
      if (ar_busy && i_m_arready) ar_busy = 0;
      if (can_acc) begin
        ar_busy   = 1;
        ar_addr_m = win ? i_dm_araddr : i_im_araddr;
        ar_prot_m = win ? i_dm_arprot : i_im_arprot;
        q_ids.push_back(win);
        last_dm = win;
        if (win) dm_pend = 0; else im_pend = 0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
